fetch_pc_gen: RTL

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

---
 rtl/banff_fetch_pkg.sv | 20 ++
 rtl/pc_next_mux.sv | 34 +++
 rtl/fetch_pc_gen.sv | 109 ++++++++++
 3 files changed

// File: rtl/banff_fetch_pkg.sv
// Shared definitions for the fetch PC generator: FSM state encoding and
// alignment helpers derived from the instruction size.
package banff_fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam int INSTR_BYTES_DEFAULT = 4;

    // Number of low address bits that must be zero for an aligned target.
    function automatic int align_bits(input int instr_bytes);
        return $clog2(instr_bytes);
    endfunction

    localparam int ALIGN_BITS_DEFAULT = align_bits(INSTR_BYTES_DEFAULT);

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select: trap > redirect > sequential advance > hold,
// with loaded targets forced onto an instruction boundary.
module pc_next_mux
    import banff_fetch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
    input  logic [XLEN-1:0] cur_pc_i,
    input  logic            advance_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vector_i,
    output logic [XLEN-1:0] next_pc_o
);

    localparam int              AB         = align_bits(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-AB){1'b1}}, {AB{1'b0}}};
    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);

    always_comb begin
        next_pc_o = cur_pc_i;
        if (trap_valid_i) begin
            next_pc_o = trap_vector_i & ALIGN_MASK;
        end else if (redirect_valid_i) begin
            next_pc_o = redirect_pc_i & ALIGN_MASK;
        end else if (advance_i) begin
            // Natural modulo-2^XLEN wrap, no overflow flag.
            next_pc_o = cur_pc_i + STEP;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: BOOT/FETCH/HALTED sequencing, trap/redirect handling
// and registered fetch outputs. Next-PC selection lives in pc_next_mux.
module fetch_pc_gen
    import banff_fetch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSTR_BYTES  = INSTR_BYTES_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            pc_ready,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            halt_req,
    input  logic            resume_req,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            flush,
    output logic [XLEN-1:0] epc,
    output logic            halted
);

    // state     | meaning
    // ST_BOOT   | single cycle after reset, no fetch issued
    // ST_FETCH  | issuing fetches, pc advances on accepted requests
    // ST_HALTED | fetch stopped, pc held (redirects still load it)
    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] epc_q;
    logic            pc_valid_q;
    logic            flush_q;
    logic            halted_q;
    logic            advance;

    assign advance = (state_q == ST_FETCH) && pc_ready && !stall;

    pc_next_mux #(
        .XLEN        (XLEN),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_pc_next_mux (
        .cur_pc_i         (pc_q),
        .advance_i        (advance),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .trap_valid_i     (trap_valid),
        .trap_vector_i    (trap_vector),
        .next_pc_o        (pc_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            flush_q <= trap_valid || redirect_valid;
            // Traps win over everything else and also wake a halted core.
            if (trap_valid) begin
                epc_q      <= pc_q;
                state_q    <= ST_FETCH;
                pc_valid_q <= 1'b1;
                halted_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_BOOT: begin
                        state_q    <= ST_FETCH;
                        pc_valid_q <= 1'b1;
                        halted_q   <= 1'b0;
                    end
                    ST_FETCH: begin
                        if (halt_req) begin
                            state_q    <= ST_HALTED;
                            pc_valid_q <= 1'b0;
                            halted_q   <= 1'b1;
                        end
                    end
                    ST_HALTED: begin
                        if (resume_req) begin
                            state_q    <= ST_FETCH;
                            pc_valid_q <= 1'b1;
                            halted_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q    <= ST_BOOT;
                        pc_valid_q <= 1'b0;
                        halted_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pc       = pc_q;
    assign pc_valid = pc_valid_q;
    assign flush    = flush_q;
    assign epc      = epc_q;
    assign halted   = halted_q;

endmodule
